// File: rtl/lcd_panel_responder.sv
// lcd_panel_responder
//   Panel-side responder for an 8-bit HD44780-style bus. It samples the
//   e/rs/rw/lcd_data strobes, decodes instructions and data writes on the
//   falling edge of e, and keeps the 128-byte DDRAM, the address counter
//   and the busy flag. It also answers status and data reads.
//
//   Optional feature: define LCD_PROTOCOL_CHECK_EN to add the sticky
//   proto_err output and its bus-protocol checker.
//
// Ports
//   clk       in   clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   e         in   bus enable strobe
//   rs        in   register select (0 instruction/status, 1 data)
//   rw        in   0 write, 1 read
//   lcd_data  in   [7:0] write data bus
//   rd_data   out  [7:0] read data bus
//   busy_flag out  panel busy
//   ac        out  [6:0] address counter
//   disp_cfg  out  [5:0] {dl_8bit, two_line, display_on, cursor_on, blink_on, inc}
//   dbg_addr  in   [6:0] DDRAM peek address
//   dbg_data  out  [7:0] DDRAM[dbg_addr], combinational
//   proto_err out  sticky protocol error (LCD_PROTOCOL_CHECK_EN only)
module lcd_panel_responder #(
  parameter int CLK_FREQ = 2,
  parameter int T_CMD    = 40,
  parameter int T_HOME   = 200,
  parameter int CBITS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] ac,
  output logic [5:0] disp_cfg,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
`ifdef LCD_PROTOCOL_CHECK_EN
  ,
  output logic       proto_err
`endif
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  localparam logic [CBITS-1:0] CMD_CNT  = CBITS'(T_CMD * CLK_FREQ - 1);
  localparam logic [CBITS-1:0] HOME_CNT = CBITS'(T_HOME * CLK_FREQ - 1);

  // Address counter step, wrapping modulo 128 in both directions.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    return up ? a + 7'd1 : a - 7'd1;
  endfunction

  logic [7:0]       mem [128];
  logic [1:0]       state;
  logic [CBITS-1:0] cnt;
  logic [6:0]       fill_ptr;
  logic             e_q;
  logic             rs_h, rw_h;
  logic [7:0]       data_h;
  logic             dl_8bit, two_line, display_on, cursor_on, blink_on, inc;

  logic             fall, accept;
  logic             mem_we;
  logic [6:0]       mem_addr;
  logic [7:0]       mem_wdata;

  assign fall     = e_q & ~e;
  // Writes are only honoured when idle; busy_flag is low exactly in S_IDLE.
  assign accept   = fall & ~rw_h & (state == S_IDLE);
  assign disp_cfg = {dl_8bit, two_line, display_on, cursor_on, blink_on, inc};
  assign dbg_data = mem[dbg_addr];

  // Bus capture: hold regs keep the last values seen while e was high,
  // so the falling-edge decode does not depend on the bus after e drops.
  always_ff @(posedge clk) begin
    if (e) begin
      rs_h   <= rs;
      rw_h   <= rw;
      data_h <= lcd_data;
    end
  end

  // DDRAM port: fill has priority, otherwise an accepted data write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = fill_ptr;
    mem_wdata = 8'h20;
    if (state == S_FILL) begin
      mem_we = 1'b1;
    end else if (accept && rs_h) begin
      mem_we    = 1'b1;
      mem_addr  = ac;
      mem_wdata = data_h;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Control: FSM, address counter, configuration, read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FILL;
      cnt        <= '0;
      fill_ptr   <= 7'd0;
      e_q        <= 1'b0;
      rd_data    <= 8'h00;
      busy_flag  <= 1'b1;
      ac         <= 7'd0;
      dl_8bit    <= 1'b1;
      two_line   <= 1'b0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      inc        <= 1'b1;
    end else begin
      e_q <= e;
      if (e && rw) rd_data <= rs ? mem[ac] : {busy_flag, ac};
      // Data reads step the counter in any state and never set busy.
      if (fall && rw_h && rs_h) ac <= ac_step(ac, inc);

      case (state)
        S_FILL: begin
          fill_ptr <= fill_ptr + 7'd1;
          if (fill_ptr == 7'd127) begin
            state     <= S_IDLE;
            busy_flag <= 1'b0;
            ac        <= 7'd0;
            inc       <= 1'b1;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state     <= S_IDLE;
            busy_flag <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state     <= S_BUSY;
            busy_flag <= 1'b1;
            cnt       <= CMD_CNT;
            if (rs_h) begin
              ac <= ac_step(ac, inc);
            end else begin
              casez (data_h)
                8'b1???????: ac <= data_h[6:0];
                8'b01??????: ;
                8'b001?????: begin
                  dl_8bit  <= data_h[4];
                  two_line <= data_h[3];
                end
                8'b0001????: if (!data_h[3]) ac <= ac_step(ac, data_h[2]);
                8'b00001???: begin
                  display_on <= data_h[2];
                  cursor_on  <= data_h[1];
                  blink_on   <= data_h[0];
                end
                8'b000001??: inc <= data_h[1];
                8'b0000001?: begin
                  ac  <= 7'd0;
                  cnt <= HOME_CNT;
                end
                8'b00000001: begin
                  state    <= S_FILL;
                  fill_ptr <= 7'd0;
                  ac       <= 7'd0;
                  inc      <= 1'b1;
                end
                default: begin
                  state     <= S_IDLE;
                  busy_flag <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

`ifdef LCD_PROTOCOL_CHECK_EN
  logic [CBITS-1:0] pw;

  // pw counts the cycles of the current e-high pulse, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw        <= '0;
      proto_err <= 1'b0;
    end else begin
      if (e) pw <= !e_q ? CBITS'(1) : ((pw == '1) ? pw : pw + 1'b1);
      if ((fall && !rw_h && busy_flag) ||
          (e && e_q && ((rs != rs_h) || (rw != rw_h))) ||
          (fall && (pw < CBITS'(CLK_FREQ))))
        proto_err <= 1'b1;
    end
  end
`endif

endmodule
